// File: rtl/booth4_pkg.sv
// Shared types and constants for the radix-4 Booth MAC engine.
// Holds the FSM states, the Booth digit selections and their control table.
package booth4_pkg;

   localparam int OPND_W = 8;
   localparam int PP_W   = 9;
   localparam int SUM_W  = 10;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      M1   = 3'd3,
      M2   = 3'd4
   } booth_sel_e;

   typedef struct packed {
      logic zero;
      logic two;
      logic neg;
   } digit_t;

   function automatic booth_sel_e booth_sel(input logic [2:0] w);
      booth_sel_e s;
      unique case (w)
         3'b000, 3'b111: s = ZERO;
         3'b001, 3'b010: s = P1;
         3'b011:         s = P2;
         3'b100:         s = M2;
         default:        s = M1;
      endcase
      return s;
   endfunction

   // neg doubles as the adder carry-in: subtract = invert plus one
   function automatic digit_t sel_ctl(input booth_sel_e s);
      digit_t d;
      d = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
      unique case (s)
         P1:      d = '{zero: 1'b0, two: 1'b0, neg: 1'b0};
         P2:      d = '{zero: 1'b0, two: 1'b1, neg: 1'b0};
         M1:      d = '{zero: 1'b0, two: 1'b0, neg: 1'b1};
         M2:      d = '{zero: 1'b0, two: 1'b1, neg: 1'b1};
         default: d = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth window encoder.
// Maps a 3-bit multiplier window to zero / double / negate controls.
module booth_r4_digit_enc
   import booth4_pkg::*;
(
   input  logic [2:0] window,
   output logic       zero,
   output logic       two,
   output logic       neg
);

   digit_t d;

   assign d    = sel_ctl(booth_sel(window));
   assign zero = d.zero;
   assign two  = d.two;
   assign neg  = d.neg;

endmodule

// File: rtl/sqrt_csa_rsa.sv
// Shared 9-bit signed add/sub unit with a 10-bit result.
// cin=1 subtracts b from a.
module sqrt_csa_rsa (
   input  logic [8:0] a,
   input  logic [8:0] b,
   input  logic       cin,
   output logic [9:0] sum
);

   logic [8:0] b_x;

   assign b_x = b ^ {9{cin}};
   assign sum = {a[8], a} + {b_x[8], b_x} + {9'd0, cin};

endmodule

// File: rtl/booth4_mac_seq.sv
// Sequential signed 8x8 radix-4 Booth multiply-accumulate engine.
// One operand pair per 6 cycles; result held until consumed.
module booth4_mac_seq
   import booth4_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              busy
);

   if (DATA_W != OPND_W) begin : g_bad_data_w
      $error("booth4_mac_seq: DATA_W must be 8");
   end
   if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("booth4_mac_seq: ACC_W must be >= 16");
   end

   state_e state;
   state_e state_nx;

   logic [1:0]        step;
   logic [DATA_W-1:0] a_r;
   logic [PP_W-1:0]   hi;
   logic [DATA_W-1:0] lo;
   logic              q_m1;
   logic              last_r;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  out_acc_r;

   logic              zero;
   logic              two;
   logic              neg;
   logic [PP_W-1:0]   add_b;
   logic              cin;
   logic [SUM_W-1:0]  sum;
   logic [PP_W-1:0]   hi_nx;
   logic [DATA_W-1:0] lo_nx;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_x;
   logic [ACC_W-1:0]         acc_sum;

   booth_r4_digit_enc u_enc (
      .window ({lo[1:0], q_m1}),
      .zero   (zero),
      .two    (two),
      .neg    (neg)
   );

   always_comb begin
      add_b = '0;
      if (!zero) begin
         add_b = two ? {a_r, 1'b0} : {a_r[DATA_W-1], a_r};
      end
   end

   assign cin = neg & ~zero;

   sqrt_csa_rsa u_add (
      .a   (hi),
      .b   (add_b),
      .cin (cin),
      .sum (sum)
   );

   // arithmetic shift right by 2 across the hi:lo pair
   assign hi_nx = {sum[SUM_W-1], sum[SUM_W-1:2]};
   assign lo_nx = {sum[1:0], lo[DATA_W-1:2]};

   assign prod    = {hi[DATA_W-1:0], lo};
   assign prod_x  = ACC_W'(prod);
   assign acc_sum = acc + prod_x;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = MUL;
         MUL:  if (step == 2'd3) state_nx = ACC;
         ACC:  state_nx = last_r ? DONE : IDLE;
         DONE: if (out_ready) state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         step      <= '0;
         a_r       <= '0;
         hi        <= '0;
         lo        <= '0;
         q_m1      <= 1'b0;
         last_r    <= 1'b0;
         acc       <= '0;
         out_acc_r <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= in_a;
                  lo     <= in_b;
                  hi     <= '0;
                  q_m1   <= 1'b0;
                  last_r <= in_last;
                  step   <= '0;
               end
            end
            MUL: begin
               hi   <= hi_nx;
               lo   <= lo_nx;
               q_m1 <= lo[1];
               step <= step + 2'd1;
            end
            ACC: begin
               acc <= acc_sum;
               if (last_r) out_acc_r <= acc_sum;
            end
            DONE: begin
               if (out_ready) acc <= '0;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE) && !rst;
   assign busy      = (state != IDLE) && !rst;
   assign out_acc   = rst ? '0 : out_acc_r;

endmodule

// File: tb/tb_booth4_mac_seq.sv
// Directed and random checks for booth4_mac_seq.
// Runs a 24-bit and a 16-bit accumulator instance in lockstep.
module tb_booth4_mac_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_last;
   logic        out_ready;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] out_acc;
   logic        busy;
   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] out_acc16;
   logic        busy16;

   int passed = 0;
   int total  = 0;

   booth4_mac_seq #(.DATA_W(8), .ACC_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .busy      (busy)
   );

   booth4_mac_seq #(.DATA_W(8), .ACC_W(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready16),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .out_acc   (out_acc16),
      .busy      (busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int a;
      int b;
      bit last;
      int hold;
      int exp;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
      int n;
      n = 0;
      in_a     = a;
      in_b     = b;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc, output bit seen_rdy);
      cyc      = 0;
      seen_rdy = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) seen_rdy = 1'b1;
         tick();
         cyc++;
      end
      if (in_ready) seen_rdy = 1'b1;
   endtask

   task automatic wait_rdy(output int cyc);
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int  cyc;
      bit  seen;
      bit  stable;
      int  pairs;
      int  n;
      longint m;
      logic signed [7:0] ra;
      logic signed [7:0] rb;

      tbl[0] = '{a: 7,    b: -3,   last: 1, hold: 0,  exp: -21};
      tbl[1] = '{a: -128, b: -128, last: 1, hold: 0,  exp: 16384};
      tbl[2] = '{a: 127,  b: -128, last: 1, hold: 0,  exp: -16256};
      tbl[3] = '{a: 127,  b: 127,  last: 1, hold: 0,  exp: 16129};
      tbl[4] = '{a: 0,    b: -77,  last: 1, hold: 0,  exp: 0};
      tbl[5] = '{a: 5,    b: -11,  last: 0, hold: 0,  exp: 0};
      tbl[6] = '{a: -26,  b: 6,    last: 0, hold: 0,  exp: 0};
      tbl[7] = '{a: 36,   b: 27,   last: 1, hold: 10, exp: 761};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_acc", out_acc, 0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         send(8'(tbl[i].a), 8'(tbl[i].b), tbl[i].last);
         if (tbl[i].last) begin
            wait_out(cyc, seen);
            chk("lat_out", cyc, 5);
            chk("rdy_low", seen, 0);
            chk("acc", longint'($signed(out_acc)), tbl[i].exp);
            stable = 1'b1;
            for (int k = 0; k < tbl[i].hold; k++) begin
               tick();
               if (!out_valid || in_ready ||
                   $signed(out_acc) != tbl[i].exp) stable = 1'b0;
            end
            if (tbl[i].hold > 0) chk("bp_stable", stable, 1);
            consume();
            chk("done_in_ready", in_ready, 1);
            chk("done_out_valid", out_valid, 0);
         end else begin
            wait_rdy(cyc);
            chk("lat_rdy", cyc, 5);
            chk("no_out", out_valid, 0);
         end
      end

      send(8'd2, 8'd3, 1'b1);
      wait_out(cyc, seen);
      chk("after_bp_acc", longint'($signed(out_acc)), 6);
      consume();

      send(8'd100, 8'd100, 1'b0);
      wait_rdy(cyc);
      send(8'd50, 8'd50, 1'b1);
      tick();
      tick();
      chk("mid_mul_busy", busy, 1);
      rst = 1'b1;
      tick();
      chk("rstmid_in_ready", in_ready, 0);
      chk("rstmid_out_valid", out_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_out_acc", out_acc, 0);
      rst = 1'b0;
      tick();
      send(8'd6, 8'd3, 1'b1);
      wait_out(cyc, seen);
      chk("post_rst_acc", longint'($signed(out_acc)), 18);
      consume();

      pairs = 0;
      while (pairs < 2000) begin
         n = $urandom_range(1, 16);
         if (pairs + n > 2000) n = 2000 - pairs;
         m = 0;
         for (int j = 0; j < n; j++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            m += longint'(ra) * longint'(rb);
            send(ra, rb, j == n - 1);
         end
         pairs += n;
         wait_out(cyc, seen);
         chk("rnd_acc24", longint'($signed(out_acc)),
             longint'($signed(m[23:0])));
         chk("rnd_acc16", longint'($signed(out_acc16)),
             longint'($signed(m[15:0])));
         consume();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
